ticked_ram: RTL and testbench
=============================

# ticked_ram

Parametrised, tick-gated, single-port synchronous RAM that serves as the CPU's main memory. It generalises the fixed 64K x 8 memory with configurable data width, address width and depth, per-byte write enables, a read-valid strobe, and out-of-range detection. Requests are sampled on `Tick`, the array is accessed one cycle later, and read data is registered one further cycle later. It sits between the CPU bus logic and the on-chip block RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 16: address bus width.
- `DEPTH`, 65536: number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- `INIT_FILE`, "": hex image loaded at elaboration with `$readmemh`. An empty string means no load; contents are then undefined.
- `OOR_DATA`, 0: value returned by an out-of-range read.

Ports (one clock; reset is asynchronous and active-high):
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Tick`  in  1  request strobe; sampled on the rising edge of `Clock`.
- `Address`  in  ADDR_WIDTH  word address.
- `DataIn`  in  DATA_WIDTH  write data.
- `ByteEn`  in  DATA_WIDTH/8  per-byte write enable; bit i covers `DataIn[8i+7:8i]`.
- `WE`  in  1  write request.
- `OE`  in  1  read request.
- `DataOut`  out  DATA_WIDTH  registered read data.
- `DataValid`  out  1  one-cycle pulse: `DataOut` was updated this cycle.
- `RangeErr`  out  1  one-cycle pulse, aligned with `DataValid`: the read was out of range.
- `ParityErr`  out  1  one-cycle pulse, aligned with `DataValid`: parity mismatch on a read. Tied to 0 unless parity is compiled in.

## Operation
- S0 capture: on an edge with `Tick`=1, register `Address`, `DataIn`, `ByteEn`, `WE` and `OE`. Set the stage-1 valid bit `v1` to `Tick`. The request registers are otherwise unchanged.
- S1 array access: when `v1`=1:
  - If `WE`=1 and the address is in range, write every byte whose `ByteEn` bit is set.
  - If `OE`=1, read the word. The read is read-first: a simultaneous write returns the old contents.
  - Set `v2` to (`v1` & `OE`), and latch the range flag.
- S2 output: when `v2`=1, load `DataOut` with the read word, or with `OOR_DATA` if out of range. Pulse `DataValid`. Pulse `RangeErr` if out of range. When `v2`=0, `DataOut` holds its value.
- Out of range means `Address` >= `DEPTH`. Writes to such an address are dropped silently; no error is flagged for writes.
- `WE`=0 and `OE`=0 with `Tick`: the request passes through the pipeline with no effect.
- `ByteEn`=0 with `WE`=1: no array change.
- Fully pipelined: a new request may be issued on every cycle. A write followed by a read of the same address on the next tick returns the new data, because the S1 accesses are in order.
- Memory contents are never reset.

## Timing
- Reset values: `DataOut`=0, `DataValid`=0, `RangeErr`=0, `ParityErr`=0; `v1`=`v2`=0; request registers = 0.
- Read latency: `Tick` sampled at edge N, array read at edge N+1, `DataOut` and `DataValid` driven after edge N+2, so `DataValid` is high during cycle N+2 to N+3.
- Write latency: the array is updated at edge N+1.
- Reset asserted mid-operation clears `v1` and `v2` immediately:
  - A write that has not yet reached its S1 edge is not performed.
  - A pending read produces no `DataValid`.
- `Tick` sampled on the same edge that reset deasserts is ignored only if `Reset` is still high at that edge.

## Configuration
- `TICKED_RAM_PARITY_EN` defined:
  - Each stored word carries DATA_WIDTH/8 extra even-parity bits, one per byte, computed from `DataIn` on write.
  - Only enabled bytes update their parity bit.
  - On an in-range read, every byte's parity is checked in S1. Any mismatch pulses `ParityErr` together with `DataValid`. Data is still delivered unchanged.
- Not defined: no parity storage; `ParityErr` is constant 0.

## Test plan
- Reset with `Tick`=1 held: `DataOut`=0 and no `DataValid` while `Reset`=1. First read after release of address 0x0000 (with `INIT_FILE` loaded with 0xA2 at 0) -> `DataValid` at edge N+2, `DataOut`=0xA2.
- DATA_WIDTH=16:
  - Write 0xBEEF to 0x0010 with `ByteEn`=11, then write 0x1234 with `ByteEn`=01.
  - Read 0x0010 -> 0xBE34.
- Back-to-back ticks:
  - Write 0x55 to 0x0100 at edge N; read 0x0100 with `WE`=1 and `DataIn`=0x66 at edge N+1 -> `DataOut`=0x55 (read-first).
  - A further read at edge N+2 -> 0x66.
  - `DataValid` is high on consecutive cycles.
- DEPTH=1024, `OOR_DATA`=0xFF:
  - Write 0x77 to 0x0400, then read 0x0400 -> `DataOut`=0xFF, `RangeErr`=1.
  - Read 0x0000 is unchanged.
- Reset pulse one cycle after `Tick` of a write to 0x0020 (0x99 over the old value 0x11): a later read returns 0x11 and no `DataValid` from the aborted request.
- With `TICKED_RAM_PARITY_EN`:
  - Force-flip one stored data bit via a hierarchical reference, then read -> `ParityErr`=1 with `DataValid`, and data is returned as stored.
  - A clean read -> `ParityErr`=0.

Source files
------------

// File: rtl/ticked_ram_if.sv
// Request/response bundle between the CPU bus logic and ticked_ram.
interface ticked_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                    Tick;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   DataIn;
  logic [DATA_WIDTH/8-1:0] ByteEn;
  logic                    WE;
  logic                    OE;
  logic [DATA_WIDTH-1:0]   DataOut;
  logic                    DataValid;
  logic                    RangeErr;
  logic                    ParityErr;

  modport master (
    output Tick, Address, DataIn, ByteEn, WE, OE,
    input  DataOut, DataValid, RangeErr, ParityErr
  );

  modport slave (
    input  Tick, Address, DataIn, ByteEn, WE, OE,
    output DataOut, DataValid, RangeErr, ParityErr
  );
endinterface

// File: rtl/ticked_ram.sv
// Tick-gated single-port RAM: capture (S0), read-first array access (S1), registered output (S2).
// Optional per-byte even parity is compiled in with `define TICKED_RAM_PARITY_EN.
module ticked_ram #(
  parameter int                  DATA_WIDTH = 8,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  DEPTH      = 65536,
  parameter string               INIT_FILE  = "",
  parameter logic [DATA_WIDTH-1:0] OOR_DATA = '0
) (
  input logic        Clock,
  input logic        Reset,
  ticked_ram_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [NB-1:0]         be_q;
  logic                  we_q;
  logic                  oe_q;
  logic                  v1;
  logic                  v2;
  logic                  oor2;
  logic                  perr2;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = ({1'b0, addr_q} < DEPTH_W);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q        <= '0;
      din_q         <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      oe_q          <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      oor2          <= 1'b0;
      bus.DataOut   <= '0;
      bus.DataValid <= 1'b0;
      bus.RangeErr  <= 1'b0;
      bus.ParityErr <= 1'b0;
    end else begin
      v1 <= bus.Tick;
      if (bus.Tick) begin
        addr_q <= bus.Address;
        din_q  <= bus.DataIn;
        be_q   <= bus.ByteEn;
        we_q   <= bus.WE;
        oe_q   <= bus.OE;
      end
      v2 <= v1 & oe_q;
      if (v1) oor2 <= ~in_range;
      bus.DataValid <= v2;
      bus.RangeErr  <= v2 & oor2;
      bus.ParityErr <= v2 & perr2;
      if (v2) bus.DataOut <= oor2 ? OOR_DATA : rd_q;
    end
  end

  // Array is never reset; v1 is, so an aborted request never reaches it.
  always_ff @(posedge Clock) begin
    if (v1) begin
      if (oe_q) rd_q <= mem[idx];
      if (we_q && in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (be_q[b]) mem[idx][8*b +: 8] <= din_q[8*b +: 8];
        end
      end
    end
  end

`ifdef TICKED_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_bad;

  always_comb begin
    par_bad = '0;
    for (int b = 0; b < NB; b++) begin
      par_bad[b] = (^mem[idx][8*b +: 8]) ^ par_mem[idx][b];
    end
  end

  always_ff @(posedge Clock) begin
    if (v1 && we_q && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) par_mem[idx][b] <= ^din_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)   perr2 <= 1'b0;
    else if (v1) perr2 <= in_range & oe_q & (|par_bad);
  end
`else
  assign perr2 = 1'b0;
`endif
endmodule

// File: tb/tb_ticked_ram.sv
// Randomized check of ticked_ram (16-bit, 1024 words, OOR_DATA=FFFF) against a word-array model.
module tb_ticked_ram;
  localparam int          DW    = 16;
  localparam int          AW    = 16;
  localparam int          DEPTH = 1024;
  localparam logic [15:0] OOR   = 16'hFFFF;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ticked_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ticked_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_FILE(""), .OOR_DATA(OOR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl   [DEPTH];
  logic [1:0]  bad_m [DEPTH];

  // Model pipeline: request accepted last edge, and read result due at the next edge.
  bit          s1_v, s1_we, s1_oe;
  logic [15:0] s1_a, s1_d;
  logic [1:0]  s1_be;
  bit          s2_v, s2_rng, s2_perr;
  logic [15:0] s2_d;
  logic [15:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    bit          rst_e, tk, we, oe, ev, er, ep;
    logic [15:0] a, d;
    logic [1:0]  be;
    @(posedge Clock);
    rst_e = Reset; tk = bus.Tick; we = bus.WE; oe = bus.OE;
    a = bus.Address; d = bus.DataIn; be = bus.ByteEn;
    #1;
    if (rst_e) begin
      s1_v = 0; s2_v = 0; exp_dout = '0; ev = 0; er = 0; ep = 0;
    end else begin
      ev = s2_v; er = s2_v & s2_rng; ep = s2_v & s2_perr;
      if (s2_v) exp_dout = s2_d;
      s2_v = 0;
      if (s1_v) begin
        if (s1_a >= 16'(DEPTH)) begin
          s2_rng = 1; s2_d = OOR; s2_perr = 0;
        end else begin
          s2_rng  = 0;
          s2_d    = mdl[s1_a[9:0]];
          s2_perr = |bad_m[s1_a[9:0]];
          if (s1_we) begin
            if (s1_be[0]) mdl[s1_a[9:0]][7:0]  = s1_d[7:0];
            if (s1_be[1]) mdl[s1_a[9:0]][15:8] = s1_d[15:8];
            bad_m[s1_a[9:0]] = bad_m[s1_a[9:0]] & ~s1_be;
          end
        end
        s2_v = s1_oe;
      end
      s1_v = tk;
      if (tk) begin
        s1_we = we; s1_oe = oe; s1_a = a; s1_d = d; s1_be = be;
      end
    end
    chk("valid", {31'b0, bus.DataValid}, {31'b0, ev});
    chk("dout",  {16'b0, bus.DataOut},   {16'b0, exp_dout});
    chk("rng",   {31'b0, bus.RangeErr},  {31'b0, er});
    chk("perr",  {31'b0, bus.ParityErr}, {31'b0, ep});
  endtask

  task automatic drive(input bit rst, input bit tk, input bit we, input bit oe,
                       input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge Clock);
    bus.Tick = tk; bus.WE = we; bus.OE = oe;
    bus.Address = a; bus.DataIn = d; bus.ByteEn = be;
    if (rst && !Reset) begin
      Reset = 1'b1;
      #1;
      s1_v = 0; s2_v = 0; exp_dout = '0;
      chk("async_valid", {31'b0, bus.DataValid}, 32'd0);
      chk("async_dout",  {16'b0, bus.DataOut},   32'd0);
    end else begin
      Reset = rst;
    end
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  initial begin
    logic [15:0] ra;
    Reset = 1'b1;
    bus.Tick = 0; bus.WE = 0; bus.OE = 0;
    bus.Address = '0; bus.DataIn = '0; bus.ByteEn = '0;
    s1_v = 0; s2_v = 0; exp_dout = '0;
    for (int i = 0; i < DEPTH; i++) bad_m[i] = 2'b00;

    // Reset held with Tick high: nothing may come out.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 16'h0, 16'h0, 2'b00);

    // First request right after release, then read-latency check.
    drive(0, 1, 1, 0, 16'h0000, 16'h00A2, 2'b11);
    drive(0, 1, 0, 1, 16'h0000, 16'h0, 2'b00);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    chk("lat_early", {31'b0, bus.DataValid}, 32'd0);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    chk("lat_valid", {31'b0, bus.DataValid}, 32'd1);
    chk("lat_data",  {16'b0, bus.DataOut},   32'h00A2);

    for (int i = 0; i < DEPTH; i++) drive(0, 1, 1, 0, 16'(i), 16'($urandom), 2'b11);

    // Byte-enable merge.
    drive(0, 1, 1, 0, 16'h0010, 16'hBEEF, 2'b11);
    drive(0, 1, 1, 0, 16'h0010, 16'h1234, 2'b01);
    drive(0, 1, 0, 1, 16'h0010, 16'h0, 2'b00);
    idle(2);
    chk("be_merge", {16'b0, bus.DataOut}, 32'h0000BE34);

    // Back-to-back: read-first, then in-order read of the new data.
    drive(0, 1, 1, 0, 16'h0100, 16'h0055, 2'b11);
    drive(0, 1, 1, 1, 16'h0100, 16'h0066, 2'b11);
    drive(0, 1, 0, 1, 16'h0100, 16'h0, 2'b00);
    idle(1);
    chk("rf_old", {16'b0, bus.DataOut}, 32'h0055);
    idle(1);
    chk("rf_new",   {16'b0, bus.DataOut},   32'h0066);
    chk("rf_valid", {31'b0, bus.DataValid}, 32'd1);

    // Out of range at DEPTH.
    drive(0, 1, 1, 0, 16'h0400, 16'h0077, 2'b11);
    drive(0, 1, 0, 1, 16'h0400, 16'h0, 2'b00);
    drive(0, 1, 0, 1, 16'h0000, 16'h0, 2'b00);
    idle(1);
    chk("oor_data", {16'b0, bus.DataOut},  32'hFFFF);
    chk("oor_flag", {31'b0, bus.RangeErr}, 32'd1);
    idle(2);

    // Reset one cycle after a write tick, with a read also in flight.
    drive(0, 1, 1, 0, 16'h0020, 16'h0011, 2'b11);
    idle(2);
    drive(0, 1, 0, 1, 16'h0030, 16'h0, 2'b00);
    drive(0, 1, 1, 0, 16'h0020, 16'h0099, 2'b11);
    drive(1, 1, 0, 1, 16'h0020, 16'h0, 2'b00);
    drive(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    idle(2);
    chk("abort_novalid", {31'b0, bus.DataValid}, 32'd0);
    drive(0, 1, 0, 1, 16'h0020, 16'h0, 2'b00);
    idle(2);
    chk("abort_data", {16'b0, bus.DataOut}, 32'h0011);

    // Randomized traffic, biased toward a small hot set to create hazards.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 16'($urandom_range(1024, 65535));
        1, 2, 3: ra = 16'($urandom_range(0, 7));
        default: ra = 16'($urandom_range(0, 1023));
      endcase
      drive(0, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
            ra, 16'($urandom), 2'($urandom));
    end
    idle(3);

`ifdef TICKED_RAM_PARITY_EN
    dut.mem[5][3] = ~dut.mem[5][3];
    mdl[5][3]     = ~mdl[5][3];
    bad_m[5][0]   = 1'b1;
    drive(0, 1, 0, 1, 16'h0005, 16'h0, 2'b00);
    drive(0, 1, 0, 1, 16'h0006, 16'h0, 2'b00);
    idle(1);
    chk("par_err",  {31'b0, bus.ParityErr}, 32'd1);
    chk("par_data", {16'b0, bus.DataOut},   {16'b0, mdl[5]});
    idle(1);
    chk("par_clean", {31'b0, bus.ParityErr}, 32'd0);
    drive(0, 1, 1, 0, 16'h0005, 16'h00C3, 2'b01);
    drive(0, 1, 0, 1, 16'h0005, 16'h0, 2'b00);
    idle(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
